// File: rtl/alu_pkg.sv
// Shared types and flag helpers for the registered ALU (alu_seq) and its serial multiplier.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ZERO  = 4'd0,
      OP_RSUB  = 4'd1,
      OP_SUB   = 4'd2,
      OP_ADD   = 4'd3,
      OP_XOR   = 4'd4,
      OP_OR    = 4'd5,
      OP_AND   = 4'd6,
      OP_ONES  = 4'd7,
      OP_INC   = 4'd8,
      OP_NOT   = 4'd9,
      OP_XNOR  = 4'd10,
      OP_SHL   = 4'd11,
      OP_SHR   = 4'd12,
      OP_MUL   = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Signed overflow from sign bits only, so these work at any WIDTH.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   function automatic logic sub_ovf(input logic m_msb, input logic s_msb, input logic d_msb);
      return (m_msb != s_msb) && (d_msb != m_msb);
   endfunction

endpackage

// File: rtl/alu_mul_serial.sv
// WIDTH-step shift-add unsigned multiplier: start loads operands, done pulses once the
// full 2*WIDTH product is valid (WIDTH cycles after start).
module alu_mul_serial #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy    <= 1'b1;
            product <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            count   <= '0;
         end else if (busy) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered handshake ALU with C/Z/V/N flags; the serial multiplier (opcode 13) exists
// only when ALU_MUL_EN is defined, otherwise opcode 13 decodes as illegal.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             c,
   output logic             z,
   output logic             v,
   output logic             n
);

   localparam int SW = $clog2(WIDTH);

   state_t           state;
   alu_op_t          opc;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   logic [WIDTH:0]   ext;
   logic [SW-1:0]    shamt;
   logic             accept;
   logic             is_mul;

   assign opc      = alu_op_t'(op);
   assign shamt    = b[SW-1:0];
   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      ext   = '0;
      case (opc)
         OP_ZERO: ;
         OP_RSUB: begin
            ext   = {1'b0, b} - {1'b0, a};
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = sub_ovf(b[WIDTH-1], a[WIDTH-1], res[WIDTH-1]);
         end
         OP_SUB: begin
            ext   = {1'b0, a} - {1'b0, b};
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = sub_ovf(a[WIDTH-1], b[WIDTH-1], res[WIDTH-1]);
         end
         OP_ADD: begin
            ext   = {1'b0, a} + {1'b0, b};
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = add_ovf(a[WIDTH-1], b[WIDTH-1], res[WIDTH-1]);
         end
         OP_XOR:  res = a ^ b;
         OP_OR:   res = a | b;
         OP_AND:  res = a & b;
         OP_ONES: res = '1;
         OP_INC: begin
            ext   = {1'b0, a} + (WIDTH+1)'(1);
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
            res_v = add_ovf(a[WIDTH-1], 1'b0, res[WIDTH-1]);
         end
         OP_NOT:  res = ~a;
         OP_XNOR: res = ~(a ^ b);
         // The extra bit beyond the operand catches the last bit shifted out.
         OP_SHL: begin
            ext   = {1'b0, a} << shamt;
            res   = ext[WIDTH-1:0];
            res_c = ext[WIDTH];
         end
         OP_SHR: begin
            ext   = {a, 1'b0} >> shamt;
            res   = ext[WIDTH:1];
            res_c = ext[0];
         end
         default: res_v = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   logic               mul_done;
   logic [2*WIDTH-1:0] product;

   assign is_mul = (opc == OP_MUL);

   alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );
`else
   assign is_mul = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         c         <= 1'b0;
         z         <= 1'b1;
         v         <= 1'b0;
         n         <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if ((state == HOLD) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               if (accept) begin
                  if (is_mul) begin
                     state     <= MUL_RUN;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out       <= res;
                     c         <= res_c;
                     v         <= res_v;
                     z         <= (res == '0);
                     n         <= res[WIDTH-1];
                  end
               end
            end
`ifdef ALU_MUL_EN
            MUL_RUN: begin
               if (mul_done) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  out       <= product[WIDTH-1:0];
                  c         <= |product[2*WIDTH-1:WIDTH];
                  v         <= |product[2*WIDTH-1:WIDTH];
                  z         <= (product[WIDTH-1:0] == '0);
                  n         <= product[WIDTH-1];
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan items plus randomized traffic,
// compared every cycle against an arithmetic reference model; honours ALU_MUL_EN.
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      int out;
      bit c;
      bit z;
      bit v;
      bit n;
   } res_t;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [W-1:0] a, b;
   logic [3:0]   op;
   logic         in_ready, out_valid, c, z, v, n;
   logic [W-1:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit   m_init  = 1'b0;
   bit   m_valid = 1'b0;
   bit   m_busy  = 1'b0;
   int   m_cnt   = 0;
   res_t m_res;
   res_t m_pend;
   logic last_ready;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .c         (c),
      .z         (z),
      .v         (v),
      .n         (n)
   );

   always #5 clk = ~clk;

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic bit out_of_range(input int s);
      return (s > 127) || (s < -128);
   endfunction

   function automatic res_t ref_op(input int o, input int ia, input int ib);
      res_t r;
      int   s, sh;
      longint p;
      r.out = 0; r.c = 0; r.v = 0;
      sh = ib % W;
      case (o)
         0: r.out = 0;
         1: begin s = ib - ia; r.out = s & 255; r.c = (ib < ia); r.v = out_of_range(sgn(ib) - sgn(ia)); end
         2: begin s = ia - ib; r.out = s & 255; r.c = (ia < ib); r.v = out_of_range(sgn(ia) - sgn(ib)); end
         3: begin s = ia + ib; r.out = s & 255; r.c = (s > 255);  r.v = out_of_range(sgn(ia) + sgn(ib)); end
         4: r.out = ia ^ ib;
         5: r.out = ia | ib;
         6: r.out = ia & ib;
         7: r.out = 255;
         8: begin s = ia + 1; r.out = s & 255; r.c = (s > 255); r.v = out_of_range(sgn(ia) + 1); end
         9: r.out = (~ia) & 255;
         10: r.out = (~(ia ^ ib)) & 255;
         11: begin r.out = (ia << sh) & 255; r.c = (sh == 0) ? 1'b0 : bit'((ia >> (W - sh)) & 1); end
         12: begin r.out = ia >> sh; r.c = (sh == 0) ? 1'b0 : bit'((ia >> (sh - 1)) & 1); end
         13: begin
            if (MUL_EN) begin
               p = longint'(ia) * longint'(ib);
               r.out = int'(p & 255);
               r.c = (p > 255);
               r.v = (p > 255);
            end else begin
               r.v = 1'b1;
            end
         end
         default: r.v = 1'b1;
      endcase
      r.z = (r.out == 0);
      r.n = bit'((r.out >> 7) & 1);
      return r;
   endfunction

   function automatic logic [11:0] pack(input res_t r);
      return {r.out[7:0], r.c, r.z, r.v, r.n};
   endfunction

   task automatic expect_eq(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, advance the model, check registered outputs.
   task automatic step(input logic r, input logic iv, input logic [3:0] o,
                       input logic [7:0] ia, input logic [7:0] ib, input logic ordy);
      bit   acc, mr;
      res_t t;
      rst = r; in_valid = iv; op = o; a = ia; b = ib; out_ready = ordy;
      #1;
      mr = !m_busy && (!m_valid || ordy);
      last_ready = in_ready;
      if (m_init && !r) expect_eq("in_ready", 16'(in_ready), 16'(mr));
      @(posedge clk);
      if (r) begin
         m_init = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
         m_res = '{0, 1'b0, 1'b1, 1'b0, 1'b0};
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 1'b0; m_valid = 1'b1; m_res = m_pend;
         end
      end else begin
         acc = iv && mr;
         if (m_valid && ordy) m_valid = 1'b0;
         if (acc) begin
            t = ref_op(int'(o), int'(ia), int'(ib));
            if (MUL_EN && o == 4'd13) begin
               m_busy = 1'b1; m_cnt = W + 1; m_pend = t;
            end else begin
               m_valid = 1'b1; m_res = t;
            end
         end
      end
      @(negedge clk);
      if (m_init) begin
         expect_eq("out_valid", 16'(out_valid), 16'(m_valid));
         expect_eq("result", 16'({out, c, z, v, n}), 16'(pack(m_res)));
      end
   endtask

   task automatic lit(input string name, input logic [7:0] eo, input logic ec, input logic ez,
                      input logic ev, input logic en);
      expect_eq({name, "_valid"}, 16'(out_valid), 16'd1);
      expect_eq(name, 16'({out, c, z, v, n}), 16'({eo, ec, ez, ev, en}));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0; out_ready = 1'b0;

      // pin the reference model with hand-computed values
      expect_eq("model_add", 16'(pack(ref_op(3, 8'h7F, 8'h01))), 16'({8'h80, 4'b0011}));
      expect_eq("model_sub", 16'(pack(ref_op(2, 8'h02, 8'h0F))), 16'({8'hF3, 4'b1001}));
      expect_eq("model_shl", 16'(pack(ref_op(11, 8'h81, 8'h03))), 16'({8'h08, 4'b0000}));
      expect_eq("model_inc", 16'(pack(ref_op(8, 8'hFF, 8'h00))), 16'({8'h00, 4'b1100}));
      expect_eq("model_ill", 16'(pack(ref_op(14, 8'h55, 8'h66))), 16'({8'h00, 4'b0110}));

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      expect_eq("reset_state", 16'({out_valid, out, c, z, v, n}), 16'({1'b0, 8'h00, 4'b0100}));
      step(0, 0, 0, 0, 0, 1);
      expect_eq("reset_ready", 16'(last_ready), 16'd1);

      step(0, 1, 4'd3, 8'h7F, 8'h01, 1);  lit("add_7f_01", 8'h80, 0, 0, 1, 1);
      step(0, 1, 4'd2, 8'h02, 8'h0F, 1);  lit("sub_02_0f", 8'hF3, 1, 0, 0, 1);
      step(0, 1, 4'd4, 8'hA5, 8'hA5, 1);  lit("xor_a5_a5", 8'h00, 0, 1, 0, 0);

      step(0, 1, 4'd3, 8'h01, 8'h02, 1);  lit("b2b_add", 8'h03, 0, 0, 0, 0);
      step(0, 1, 4'd6, 8'hF0, 8'h3C, 1);  lit("b2b_and", 8'h30, 0, 0, 0, 0);
      step(0, 1, 4'd11, 8'h81, 8'h03, 1); lit("b2b_shl", 8'h08, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);

      step(0, 1, 4'd8, 8'hFF, 8'h00, 0);  lit("inc_ff", 8'h00, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 4'd3, 8'h11, 8'h22, 0);
         expect_eq("bp_ready", 16'(last_ready), 16'd0);
         lit("bp_hold", 8'h00, 1, 1, 0, 0);
      end
      step(0, 1, 4'd6, 8'hF0, 8'hFF, 1);  lit("bp_accept", 8'hF0, 0, 0, 0, 1);

      step(0, 1, 4'd14, 8'h55, 8'h66, 1); lit("illegal14", 8'h00, 0, 1, 1, 0);
      step(0, 1, 4'd15, 8'hFF, 8'hFF, 1); lit("illegal15", 8'h00, 0, 1, 1, 0);
      if (!MUL_EN) begin
         step(0, 1, 4'd13, 8'h10, 8'h11, 1); lit("illegal13", 8'h00, 0, 1, 1, 0);
      end else begin
         step(0, 1, 4'd13, 8'h10, 8'h11, 1);
         for (int i = 1; i <= W + 1; i++) begin
            step(0, 1, 4'd3, 8'hEE, 8'hEE, 1);
            expect_eq("mul_ready", 16'(last_ready), 16'd0);
         end
         lit("mul_10_11", 8'h10, 1, 0, 1, 0);
         step(0, 1, 4'd13, 8'h33, 8'h44, 1);
         step(0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 1);
         step(1, 0, 0, 0, 0, 1);
         expect_eq("mul_rst", 16'({out_valid, z}), 16'({1'b0, 1'b1}));
         step(0, 0, 0, 0, 0, 0);
         expect_eq("mul_rst_ready", 16'(last_ready), 16'd1);
      end
      step(0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         logic [3:0] ro;
         ro = (($urandom_range(0, 9)) == 0) ? 4'd13 : 4'($urandom_range(0, 15));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), ro,
              8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
